// File: rtl/reqrsp_demux.sv
// ============================================================================
// Module   : reqrsp_demux
// Brief    : 1-to-N reqrsp request router with in-order response return.
//            Optional macro REQRSP_DEMUX_ERR_SLV_EN adds an internal error
//            port that answers out-of-range selects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reqrsp_demux #(
   parameter int unsigned NrPorts   = 4,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned RespDepth = 8,
   localparam int unsigned SelWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [SelWidth-1:0]               slv_select_i,
   input  logic                              slv_q_valid_i,
   output logic                              slv_q_ready_o,
   input  logic [AddrWidth-1:0]              slv_q_addr_i,
   input  logic                              slv_q_write_i,
   input  logic [3:0]                        slv_q_amo_i,
   input  logic [DataWidth-1:0]              slv_q_data_i,
   input  logic [DataWidth/8-1:0]            slv_q_strb_i,
   input  logic [1:0]                        slv_q_size_i,
   output logic                              slv_p_valid_o,
   input  logic                              slv_p_ready_i,
   output logic [DataWidth-1:0]              slv_p_data_o,
   output logic                              slv_p_error_o,
   output logic [NrPorts-1:0]                mst_q_valid_o,
   input  logic [NrPorts-1:0]                mst_q_ready_i,
   output logic [AddrWidth-1:0]              mst_q_addr_o,
   output logic                              mst_q_write_o,
   output logic [3:0]                        mst_q_amo_o,
   output logic [DataWidth-1:0]              mst_q_data_o,
   output logic [DataWidth/8-1:0]            mst_q_strb_o,
   output logic [1:0]                        mst_q_size_o,
   input  logic [NrPorts-1:0]                mst_p_valid_i,
   output logic [NrPorts-1:0]                mst_p_ready_o,
   input  logic [NrPorts-1:0][DataWidth-1:0] mst_p_data_i,
   input  logic [NrPorts-1:0]                mst_p_error_i
);

`ifdef REQRSP_DEMUX_ERR_SLV_EN
   localparam int unsigned FifoW = $clog2(NrPorts + 1);
`else
   localparam int unsigned FifoW = SelWidth;
`endif
   localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
   localparam int unsigned CntW = $clog2(RespDepth + 1);

   logic [FifoW-1:0] fifo_q [RespDepth];
   logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full, empty, sel_in_range, tgt_ready, push, pop;
   logic [FifoW-1:0] push_entry, head_entry;

   assign full         = (count_q == CntW'(RespDepth));
   assign empty        = (count_q == '0);
   assign sel_in_range = (32'(slv_select_i) < NrPorts);
   assign head_entry   = fifo_q[head_q];

   assign mst_q_addr_o  = slv_q_addr_i;
   assign mst_q_write_o = slv_q_write_i;
   assign mst_q_amo_o   = slv_q_amo_i;
   assign mst_q_data_o  = slv_q_data_i;
   assign mst_q_strb_o  = slv_q_strb_i;
   assign mst_q_size_o  = slv_q_size_i;

   for (genvar s = 0; s < NrPorts; s++) begin : g_q_valid
      assign mst_q_valid_o[s] = slv_q_valid_i && !full && (slv_select_i == SelWidth'(s));
   end

   always_comb begin
      tgt_ready = 1'b0;
      for (int s = 0; s < NrPorts; s++) begin
         if (slv_select_i == SelWidth'(s)) tgt_ready = mst_q_ready_i[s];
      end
   end

`ifdef REQRSP_DEMUX_ERR_SLV_EN
   // Out-of-range selects go to the internal error port, which is always ready.
   assign slv_q_ready_o = !full && (sel_in_range ? tgt_ready : 1'b1);
   assign push_entry    = sel_in_range ? FifoW'(slv_select_i) : FifoW'(NrPorts);
`else
   assign slv_q_ready_o = !full && sel_in_range && tgt_ready;
   assign push_entry    = slv_select_i;
`endif

   assign push = slv_q_valid_i && slv_q_ready_o;

   always_comb begin
      slv_p_valid_o = 1'b0;
      slv_p_data_o  = '0;
      slv_p_error_o = 1'b0;
      mst_p_ready_o = '0;
      if (!empty) begin
         for (int s = 0; s < NrPorts; s++) begin
            if (head_entry == FifoW'(s)) begin
               slv_p_valid_o    = mst_p_valid_i[s];
               slv_p_data_o     = mst_p_data_i[s];
               slv_p_error_o    = mst_p_error_i[s];
               mst_p_ready_o[s] = slv_p_ready_i;
            end
         end
`ifdef REQRSP_DEMUX_ERR_SLV_EN
         if (head_entry == FifoW'(NrPorts)) begin
            slv_p_valid_o = 1'b1;
            slv_p_error_o = 1'b1;
         end
`endif
      end
   end

   assign pop = slv_p_valid_o && slv_p_ready_i;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(RespDepth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < RespDepth; i++) fifo_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (push) fifo_q[tail_q] <= push_entry;
      end
   end

   // A stalled request must keep its target and payload until accepted or withdrawn.
   a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (slv_q_valid_i && !slv_q_ready_o) |=> (!slv_q_valid_i ||
         ($stable(slv_select_i) && $stable(slv_q_addr_i) && $stable(slv_q_write_i) &&
          $stable(slv_q_amo_i) && $stable(slv_q_data_i) && $stable(slv_q_strb_i) &&
          $stable(slv_q_size_i))));

`ifndef REQRSP_DEMUX_ERR_SLV_EN
   a_sel_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
      slv_q_valid_i |-> sel_in_range);
`endif

endmodule

`default_nettype wire

// File: doc/reqrsp_demux.md
# reqrsp_demux

Routes a single reqrsp request stream to one of `NrPorts` downstream reqrsp ports, selected per request by a port index. Responses are returned to the upstream port strictly in request order. An internal FIFO records the target port of every outstanding request. The block is the 1-to-N counterpart of `reqrsp_mux` and sits between a core/DMA initiator and its memory-side targets (TCDM, peripherals, AXI bridge).

## Interface

Parameters:

- `NrPorts`, 4, number of downstream ports (≥ 2).
- `AddrWidth`, 32, address width.
- `DataWidth`, 32, data width; strobe width is `DataWidth/8`.
- `RespDepth`, 8, maximum outstanding requests (≥ 1); sets FIFO depth.
- Derived `SelWidth = max(1, $clog2(NrPorts))`.

Ports (`[N]` means packed `[NrPorts-1:0]`):

- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `slv_select_i` in SelWidth: target port of the current request.
- `slv_q_valid_i` in 1 / `slv_q_ready_o` out 1: upstream request handshake.
- `slv_q_addr_i` in AddrWidth, `slv_q_write_i` in 1, `slv_q_amo_i` in 4, `slv_q_data_i` in DataWidth, `slv_q_strb_i` in DataWidth/8, `slv_q_size_i` in 2: request payload.
- `slv_p_valid_o` out 1 / `slv_p_ready_i` in 1: upstream response handshake.
- `slv_p_data_o` out DataWidth, `slv_p_error_o` out 1: response payload.
- `mst_q_valid_o` out [N] / `mst_q_ready_i` in [N]: downstream request handshakes.
- `mst_q_addr_o`, `mst_q_write_o`, `mst_q_amo_o`, `mst_q_data_o`, `mst_q_strb_o`, `mst_q_size_o`: shared request payload broadcast to all ports, same widths as the upstream payload.
- `mst_p_valid_i` in [N] / `mst_p_ready_o` out [N]: downstream response handshakes.
- `mst_p_data_i` in [N]×DataWidth, `mst_p_error_i` in [N]: downstream response payloads.

## Operation

- Request path is combinational.
  - `mst_q_valid_o[s] = slv_q_valid_i && !full && (slv_select_i == s)`.
  - `slv_q_ready_o = mst_q_ready_i[slv_select_i] && !full`.
  - Payload is forwarded unchanged to every port.
- A request handshake (`slv_q_valid_i && slv_q_ready_o`) pushes `slv_select_i` into the ordering FIFO at the tail.
- Response path follows the FIFO head `h`. It is valid only when the FIFO is non-empty.
  - `slv_p_valid_o = mst_p_valid_i[h]`.
  - `slv_p_data_o = mst_p_data_i[h]`, `slv_p_error_o = mst_p_error_i[h]`.
  - `mst_p_ready_o[h] = slv_p_ready_i`.
  - All other `mst_p_ready_o` bits are 0.
- A response handshake pops the FIFO head.
- Responses arriving on non-head ports are held (ready=0) until that port becomes head.
- FIFO: `RespDepth` entries of SelWidth bits, with head/tail pointers that wrap modulo `RespDepth` and an occupancy counter of width `$clog2(RespDepth+1)`.
- Full (`count == RespDepth`) blocks new requests, even when a pop occurs in the same cycle. There is no fall-through.
- Empty: `slv_p_valid_o = 0` and all `mst_p_ready_o = 0`.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- The upstream initiator holds `slv_select_i` and the payload stable while `slv_q_valid_i && !slv_q_ready_o`. This is asserted in simulation.
- `slv_select_i ≥ NrPorts` is handled per Configuration.

## Timing

- Request latency 0 cycles; response latency 0 cycles. No registers in the datapaths.
- An entry pushed in cycle t is visible at the head in cycle t+1 at the earliest. A response for a request handshaked in cycle t cannot be accepted before t+1.
- Reset (asynchronous, `rst_ni = 0`):
  - FIFO empty; count, head and tail all 0.
  - `slv_p_valid_o = 0`, all `mst_p_ready_o = 0`.
  - `slv_q_ready_o` and `mst_q_valid_o` follow their combinational equations with `full = 0`.
- Reset mid-operation discards all outstanding entries. Downstream responses still in flight are the integrator's responsibility.

## Configuration

Macro `REQRSP_DEMUX_ERR_SLV_EN` controls handling of out-of-range selects.

- Defined: an internal error port with FIFO index `NrPorts` (FIFO entries widen to `$clog2(NrPorts+1)` bits).
  - A request with `slv_select_i ≥ NrPorts` is accepted whenever the FIFO is not full; no `mst_q_valid_o` is raised.
  - When it reaches the head, the response is `slv_p_valid_o = 1`, `slv_p_data_o = 0`, `slv_p_error_o = 1`.
- Undefined: out-of-range selects are illegal.
  - A simulation assertion fires.
  - `slv_q_ready_o = 0` for such requests.

## Test plan

- Single write to port 2 (addr 0x100, data 0xDEADBEEF, strb 0xF): `mst_q_valid_o = 4'b0100` in the same cycle; port 2 responds data 0, error 0 → `slv_p_valid_o = 1`, data 0.
- Reordering: reads issued to ports 3, 0, 1; ports respond in order 1, 0, 3 with data 0x11, 0x22, 0x33 → upstream receives 0x33, 0x22, 0x11. Port 1's `mst_p_ready_o` stays 0 until the third response slot.
- Full: `RespDepth = 8`, 8 requests issued with no responses → `slv_q_ready_o = 0` on the 9th. One response handshake, then the 9th is accepted no earlier than the following cycle.
- Backpressure: `slv_p_ready_i = 0` for 5 cycles while head port valid → `mst_p_ready_o` all 0 and the FIFO count stays constant.
- Error slave: with `REQRSP_DEMUX_ERR_SLV_EN` and `NrPorts = 3`, a request with select 3 → accepted, no `mst_q_valid_o`, response error = 1, data 0, in order after earlier requests.
- Random: 4 ports, 1000 random requests with random ready/valid delays → per-port scoreboard matches and the FIFO is empty at the end. Also assert reset mid-stream → count returns to 0 immediately.
